// File: rtl/cpu_timer_irq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_timer_irq_pkg : register map and TCON bit layout of the CPU timer     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package cpu_timer_irq_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [3:0] TH_OFS      = 4'h0;
    localparam logic [3:0] TL_OFS      = 4'h4;
    localparam logic [3:0] TCON_OFS    = 4'h8;
    localparam logic [3:0] SYSTICK_OFS = 4'hC;

    localparam int EN_BIT = 0;
    localparam int IE_BIT = 1;
    localparam int ST_BIT = 2;

    // Word select inside the 16-byte window, taken from addr[3:2].
    typedef enum logic [1:0] {
        SEL_TH      = TH_OFS[3:2],
        SEL_TL      = TL_OFS[3:2],
        SEL_TCON    = TCON_OFS[3:2],
        SEL_SYSTICK = SYSTICK_OFS[3:2]
    } reg_sel_e;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_prescaler : divides the core clock into counter ticks while enabled |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] c_last = 16'(PRESCALE - 1);

    logic [15:0] r_cnt;

    // Combinational tick so that with PRESCALE=1 the tick is exactly en.
    assign tick = en && (r_cnt == c_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!en || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_timer_irq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_timer_irq : bus-mapped reloadable timer with sticky overflow IRQ      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module cpu_timer_irq
    import cpu_timer_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        pc_high,
    output logic        irq,
    output logic        interrupt
);

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [31:0] r_systick;
    logic        r_en;
    logic        r_ie;
    logic        r_st;

    logic     w_hit;
    reg_sel_e w_sel;
    logic     w_wr_th;
    logic     w_wr_tl;
    logic     w_wr_tcon;
    logic     w_run;
    logic     w_tick;
    logic     w_ovf;
    logic     w_set_st;
    logic     w_unused;

    assign w_hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_sel     = reg_sel_e'(addr[3:2]);
    assign w_wr_th   = wr && w_hit && (w_sel == SEL_TH);
    assign w_wr_tl   = wr && w_hit && (w_sel == SEL_TL);
    assign w_wr_tcon = wr && w_hit && (w_sel == SEL_TCON);
    assign w_unused  = &{1'b0, addr[1:0]};

    // A TCON write clearing EN halts counting on that very edge.
    assign w_run = r_en && !(w_wr_tcon && !wdata[EN_BIT]);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (w_run),
        .tick  (w_tick)
    );

    assign w_ovf    = w_tick && (r_tl == 32'hFFFF_FFFF);
    assign w_set_st = w_ovf && r_ie;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th <= '0;
        end else if (w_wr_th) begin
            r_th <= wdata;
        end
    end

    // Reload reads the pre-edge TH, so a same-edge TH write lands next period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tl <= '0;
        end else if (w_wr_tl) begin
            r_tl <= wdata;
        end else if (w_ovf) begin
            r_tl <= r_th;
        end else if (w_tick) begin
            r_tl <= r_tl + 32'd1;
        end
    end

    // An overflow coinciding with an acknowledge keeps ST set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en <= 1'b0;
            r_ie <= 1'b0;
            r_st <= 1'b0;
        end else if (w_wr_tcon) begin
            r_en <= wdata[EN_BIT];
            r_ie <= wdata[IE_BIT];
            r_st <= wdata[ST_BIT] | w_set_st;
        end else if (w_set_st) begin
            r_st <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && w_hit) begin
            case (w_sel)
                SEL_TH:      rdata = r_th;
                SEL_TL:      rdata = r_tl;
                SEL_TCON: begin
                    rdata[EN_BIT] = r_en;
                    rdata[IE_BIT] = r_ie;
                    rdata[ST_BIT] = r_st;
                end
                SEL_SYSTICK: rdata = r_systick;
                default:     rdata = '0;
            endcase
        end
    end

    assign irq       = r_st;
    assign interrupt = r_st && !pc_high;

endmodule
`default_nettype wire

// File: tb/tb_cpu_timer_irq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_timer_irq : directed table, corner sequences and random vs. model  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_cpu_timer_irq;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr, pc_high;
    logic [31:0] addr, wdata;
    logic [31:0] rdata1, rdata4;
    logic        irq1, irq4, int1, int4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    cpu_timer_irq #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .pc_high(pc_high), .irq(irq1), .interrupt(int1)
    );

    cpu_timer_irq #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata4), .pc_high(pc_high), .irq(irq4), .interrupt(int4)
    );

    // Reference model: architectural register state plus cycles counted since enable.
    typedef struct packed {
        logic [31:0] th;
        logic [31:0] tl;
        logic        en;
        logic        ie;
        logic        st;
        logic [31:0] ph;
        logic [31:0] sys;
    } mstate_t;

    mstate_t m1, m4;

    function automatic mstate_t mstep(mstate_t s, int p, logic w, logic [31:0] a, logic [31:0] d);
        mstate_t n    = s;
        logic    hit  = (a[31:4] == BASE[31:4]);
        logic    wtc  = w && hit && (a[3:2] == 2'd2);
        logic    run  = s.en && !(wtc && !d[0]);
        logic    tk   = run && (s.ph == 32'(p - 1));
        logic    ovf  = tk && (s.tl == 32'hFFFF_FFFF);
        n.sys = s.sys + 32'd1;
        n.ph  = run ? 32'((s.ph + 1) % p) : 32'd0;
        if (tk) n.tl = ovf ? s.th : s.tl + 32'd1;
        if (w && hit && a[3:2] == 2'd1) n.tl = d;
        if (w && hit && a[3:2] == 2'd0) n.th = d;
        if (wtc) begin
            n.en = d[0];
            n.ie = d[1];
            n.st = d[2];
        end
        if (ovf && s.ie) n.st = 1'b1;
        return n;
    endfunction

    function automatic logic [31:0] mread(mstate_t s, logic r, logic [31:0] a);
        if (!r || a[31:4] != BASE[31:4]) return 32'd0;
        case (a[3:2])
            2'd0:    return s.th;
            2'd1:    return s.tl;
            2'd2:    return {29'd0, s.st, s.ie, s.en};
            default: return s.sys;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m1 <= '0;
            m4 <= '0;
        end else begin
            m1 <= mstep(m1, 1, wr, addr, wdata);
            m4 <= mstep(m4, 4, wr, addr, wdata);
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  ofs;
        logic [31:0] wdata;
        logic        pch;
        logic [31:0] exp_rdata;
        logic        exp_irq;
        logic        exp_int;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rd = r; wr = w; addr = a; wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wreg(input logic [31:0] ofs, input logic [31:0] d);
        bus(1'b0, 1'b1, BASE + ofs, d);
        step();
        bus(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic rchk1(input string nm, input logic [31:0] ofs, input logic [31:0] exp);
        bus(1'b1, 1'b0, BASE + ofs, 32'd0);
        #1;
        chk(nm, rdata1, exp);
    endtask

    task automatic rchk4(input string nm, input logic [31:0] ofs, input logic [31:0] exp);
        bus(1'b1, 1'b0, BASE + ofs, 32'd0);
        #1;
        chk(nm, rdata4, exp);
    endtask

    initial begin
        logic [31:0] s0;
        // rd, wr, ofs, wdata, pc_high, exp_rdata, exp_irq, exp_int
        tbl[0]  = '{1'b0, 1'b1, 8'h00, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h04, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h08, 32'h3,         1'b0, 32'h0,         1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h04, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h04, 32'h0,         1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h04, 32'h0,         1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h04, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h04, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 8'h08, 32'h0,         1'b0, 32'h7,         1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h04, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h08, 32'h3,         1'b1, 32'h7,         1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h08, 32'h0,         1'b0, 32'h3,         1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h04, 32'h0,         1'b0, 32'h2,         1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 8'h08, 32'h0,         1'b0, 32'h3,         1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'h04, 32'h0,         1'b0, 32'h4,         1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 8'h04, 32'h0,         1'b0, 32'h4,         1'b0, 1'b0};

        reset = 1'b0; pc_high = 1'b0;
        bus(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Reset applied mid-count with a pending request.
        wreg(32'h4, 32'hFFFF_FFF0);
        wreg(32'h8, 32'h7);
        repeat (2) step();
        chk("pre_reset_irq", {31'd0, irq1}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_irq", {31'd0, irq1}, 32'd0);
        chk("async_reset_int", {31'd0, int1}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        rchk1("rst_th", 32'h0, 32'd0);
        rchk1("rst_tl", 32'h4, 32'd0);
        rchk1("rst_tcon", 32'h8, 32'd0);
        rchk1("rst_systick", 32'hC, 32'd0);
        chk("rst_irq4", {31'd0, irq4}, 32'd0);
        step();

        // Overflow/reload and kernel masking on the PRESCALE=1 instance.
        for (int i = 0; i < 18; i++) begin
            bus(tbl[i].rd, tbl[i].wr, BASE + {24'd0, tbl[i].ofs}, tbl[i].wdata);
            pc_high = tbl[i].pch;
            #3;
            chk($sformatf("tbl%0d_rdata", i), rdata1, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_irq", i), {31'd0, irq1}, {31'd0, tbl[i].exp_irq});
            chk($sformatf("tbl%0d_int", i), {31'd0, int1}, {31'd0, tbl[i].exp_int});
            step();
        end
        bus(1'b0, 1'b0, 32'd0, 32'd0);
        pc_high = 1'b0;

        // Acknowledge on the overflow edge must not lose the request.
        wreg(32'h0, 32'h1234_5678);
        wreg(32'h8, 32'h3);
        wreg(32'h4, 32'hFFFF_FFFF);
        wreg(32'h8, 32'h3);
        rchk1("coll_tcon", 32'h8, 32'h7);
        rchk1("coll_tl", 32'h4, 32'h1234_5678);
        wreg(32'h8, 32'h0);
        chk("ack_irq", {31'd0, irq1}, 32'd0);
        wreg(32'h8, 32'h4);
        chk("force_irq", {31'd0, irq1}, 32'd1);
        chk("force_int", {31'd0, int1}, 32'd1);
        pc_high = 1'b1;
        #1 chk("force_int_kernel", {31'd0, int1}, 32'd0);
        pc_high = 1'b0;
        wreg(32'h8, 32'h0);
        wreg(32'h4, 32'hFFFF_FFFF);
        wreg(32'h8, 32'h1);
        step();
        rchk1("noie_reload", 32'h4, 32'h1234_5678);
        chk("noie_irq", {31'd0, irq1}, 32'd0);
        wreg(32'h8, 32'h0);

        // Prescaler on the PRESCALE=4 instance.
        wreg(32'h4, 32'h0);
        wreg(32'h8, 32'h1);
        repeat (12) step();
        rchk4("ps_tl3", 32'h4, 32'h3);
        repeat (3) step();
        wreg(32'h8, 32'h0);
        repeat (3) step();
        rchk4("ps_hold", 32'h4, 32'h3);
        s0 = m4.sys;
        rchk4("ps_sys0", 32'hC, s0);
        repeat (5) step();
        rchk4("ps_sys5", 32'hC, s0 + 32'd5);
        wreg(32'h8, 32'h1);
        repeat (3) step();
        rchk4("ps_restart3", 32'h4, 32'h3);
        step();
        rchk4("ps_restart4", 32'h4, 32'h4);
        wreg(32'h8, 32'h0);

        // Bus decode.
        rchk1("dec_out_hi", 32'h10, 32'd0);
        rchk1("dec_out_lo", 32'hFFFF_FFFC, 32'd0);
        bus(1'b0, 1'b0, BASE + 32'h4, 32'd0);
        #1 chk("dec_no_rd", rdata1, 32'd0);
        s0 = m1.sys;
        bus(1'b1, 1'b1, BASE + 32'hC, 32'h0);
        #1 chk("sys_before_wr", rdata1, s0);
        step();
        step();
        rchk1("sys_after_wr", 32'hC, s0 + 32'd2);
        wreg(32'h8, 32'hFFFF_FFFF);
        rchk1("tcon_mask", 32'h8, 32'h7);
        wreg(32'h8, 32'h0);
        wreg(32'h3, 32'hA5A5_5A5A);
        wreg(32'h10, 32'h0);
        rchk1("th_lowbits", 32'h2, 32'hA5A5_5A5A);
        step();

        // Random traffic against the reference model.
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 500; i++) begin
            logic [31:0] a, d;
            int          r;
            r = $urandom_range(0, 9);
            a = BASE + 32'($urandom_range(0, 15));
            if (r == 8) a = a + 32'h10;
            if (r == 9) a = $urandom;
            d = $urandom;
            if (a[3:2] == 2'd1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
            if (a[3:2] == 2'd0 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            bus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, d);
            pc_high = 1'($urandom_range(0, 1));
            #3;
            chk("rnd_rdata1", rdata1, mread(m1, rd, addr));
            chk("rnd_irq1", {31'd0, irq1}, {31'd0, m1.st});
            chk("rnd_int1", {31'd0, int1}, {31'd0, m1.st & ~pc_high});
            chk("rnd_rdata4", rdata4, mread(m4, rd, addr));
            chk("rnd_irq4", {31'd0, irq4}, {31'd0, m4.st});
            chk("rnd_int4", {31'd0, int4}, {31'd0, m4.st & ~pc_high});
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
